// File: rtl/bcd_count_ctrl_pkg.sv
// Shared constants for the BCD counter run/pause/clear controller.
// State encodings, BCD digit limits and a nibble validity helper.
package bcd_count_ctrl_pkg;

  localparam int unsigned BCD_WIDTH = 8;
  localparam int unsigned NIB_W     = 4;

  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_RUN   = 2'd1;
  localparam logic [1:0] ST_PAUSE = 2'd2;
  localparam logic [1:0] ST_DONE  = 2'd3;

  localparam logic [NIB_W-1:0] BCD_DIGIT_MAX = 4'd9;

  // True when both nibbles of a {tens,units} value are legal BCD digits.
  function automatic logic bcd_byte_valid(input logic [BCD_WIDTH-1:0] v);
    return (v[BCD_WIDTH-1:NIB_W] <= BCD_DIGIT_MAX) && (v[NIB_W-1:0] <= BCD_DIGIT_MAX);
  endfunction

endpackage

// File: rtl/bcd_target_cmp.sv
// Target validity check and count/target equality compare.
// target_err is registered; match_c is combinational so it lines up with
// the cycle in which the digits present their freshly updated count.
module bcd_target_cmp
  import bcd_count_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = BCD_WIDTH
) (
  input  logic             sys_clk,
  input  logic             sys_reset,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] count,
  output logic             target_err,
  output logic             match_c
);

  logic r_target_err;

  // Register the target validity flag; target is sampled every cycle.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_target_err <= 1'b0;
    end else begin
      r_target_err <= ~bcd_byte_valid(target);
    end
  end

  // An invalid target disables matching; a non-BCD count cannot equal a valid target.
  assign match_c    = ~r_target_err & (count == target);
  assign target_err = r_target_err;

endmodule

// File: rtl/bcd_count_ctrl.sv
// Run/pause/clear controller for the two-digit BCD counter chain.
// Gates the tick to the units digit, issues synchronous clears and stops the
// count at a programmable BCD target.
// Build option: BCD_CTRL_AUTORELOAD_EN -- on a target match, pulse done and
// clear_out together and keep running (DONE becomes unreachable).
module bcd_count_ctrl
  import bcd_count_ctrl_pkg::*;
#(
  parameter int unsigned WIDTH = BCD_WIDTH
) (
  input  logic             sys_clk,
  input  logic             sys_reset,
  input  logic             tick_in,
  input  logic             start_stop,
  input  logic             clear,
  input  logic [WIDTH-1:0] target,
  input  logic [WIDTH-1:0] count,
  output logic             tick_out,
  output logic             clear_out,
  output logic             running,
  output logic             done,
  output logic             target_err
);

  logic [1:0] r_state;
  logic [1:0] w_state_nxt;
  logic       r_tick_out;
  logic       r_clear_out;
  logic       r_running;
  logic       r_done;
  logic       r_chk;
  logic       w_tick_nxt;
  logic       w_clear_nxt;
  logic       w_done_nxt;
  logic       w_hit;
  logic       w_match;

  bcd_target_cmp #(
    .WIDTH (WIDTH)
  ) u_target_cmp (
    .sys_clk    (sys_clk),
    .sys_reset  (sys_reset),
    .target     (target),
    .count      (count),
    .target_err (target_err),
    .match_c    (w_match)
  );

  // State register.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_state <= ST_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state and next output values; priority clear > match > start_stop.
  always_comb begin
    w_state_nxt = r_state;
    w_clear_nxt = 1'b0;
    w_done_nxt  = 1'b0;
    w_hit       = (r_state == ST_RUN) & r_chk & w_match;
    w_tick_nxt  = tick_in & (r_state == ST_RUN) & ~clear & ~start_stop;
    if (clear) begin
      w_state_nxt = ST_IDLE;
      w_clear_nxt = 1'b1;
    end else if (w_hit) begin
      w_done_nxt  = 1'b1;
`ifdef BCD_CTRL_AUTORELOAD_EN
      w_clear_nxt = 1'b1;
      w_state_nxt = ST_RUN;
`else
      w_state_nxt = ST_DONE;
`endif
    end else if (start_stop) begin
      case (r_state)
        ST_IDLE, ST_PAUSE: w_state_nxt = ST_RUN;
        ST_RUN:            w_state_nxt = ST_PAUSE;
        default:           w_state_nxt = r_state;
      endcase
    end
  end

  // Registered outputs; r_chk marks the cycle where count reflects the last tick.
  always_ff @(posedge sys_clk or posedge sys_reset) begin
    if (sys_reset) begin
      r_tick_out  <= 1'b0;
      r_clear_out <= 1'b0;
      r_running   <= 1'b0;
      r_done      <= 1'b0;
      r_chk       <= 1'b0;
    end else begin
      r_tick_out  <= w_tick_nxt;
      r_clear_out <= w_clear_nxt;
      r_running   <= (w_state_nxt == ST_RUN);
      r_done      <= w_done_nxt;
      r_chk       <= r_tick_out;
    end
  end

  assign tick_out  = r_tick_out;
  assign clear_out = r_clear_out;
  assign running   = r_running;
  assign done      = r_done;

endmodule
